// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port (data RAM plus LED/RGB MMIO) between
// the core (port 0) and a secondary master such as a loader or DMA (port 1).
// One access is issued per grant. A granted write occupies the port for
// its grant cycle only. A granted read keeps the port until its data
// returns MEM_LAT cycles later.
//
// Handshake: a master holds mN_req and its fields stable until it sees mN_gnt.
// mN_gnt is combinational in IDLE and marks the single cycle in which that
// request is accepted and driven onto the memory port. After that cycle the
// master may drop or change req and its fields, because the arbiter has
// already latched everything it still needs. A read returns as a single-cycle
// mN_rvalid pulse. mN_rdata carries mem_rd at all times and is meaningful only
// while mN_rvalid is high.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,    // read latency in cycles, 1..7
    parameter bit FIXED_PRIO = 1'b0  // 1: port 0 always wins on contention
) (
    input  logic        clk,
    input  logic        rst_n,
    // port 0 (core)
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_funct3,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    // port 1 (loader / DMA)
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_funct3,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    // memory side
    output logic        mem_wen,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_ra,
    input  logic [31:0] mem_rd,
    // FSM state for observation: 0 = IDLE, 1 = READ_WAIT
    output logic        dbg_state_o
);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } state_e;

    // The latency counter is loaded with MEM_LAT-1, so it reaches 0 in the
    // cycle the read data becomes valid.
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] ra_q, ra_d;
    logic [2:0]  f3_q, f3_d;
    logic        owner_q, owner_d;

    // Result of arbitration in the current cycle.
    logic        sel_valid;
    logic        sel_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_f3;

    // Arbitration is only live in IDLE and out of reset. On contention,
    // round-robin picks the port that did not win last time.
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
            if (m0_req && m1_req) begin
                sel_valid = 1'b1;
                sel_port  = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
            end else if (m0_req) begin
                sel_valid = 1'b1;
                sel_port  = 1'b0;
            end else if (m1_req) begin
                sel_valid = 1'b1;
                sel_port  = 1'b1;
            end
        end
    end

    // Route the winning port's request fields onto one set of selected signals.
    always_comb begin
        sel_we    = sel_port ? m1_we     : m0_we;
        sel_addr  = sel_port ? m1_addr   : m0_addr;
        sel_wdata = sel_port ? m1_wdata  : m0_wdata;
        sel_f3    = sel_port ? m1_funct3 : m0_funct3;
    end

    // State register. Reset abandons any read that is still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            lat_cnt_q  <= 3'd0;
            ra_q       <= 32'd0;
            f3_q       <= 3'd0;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lat_cnt_q  <= lat_cnt_d;
            ra_q       <= ra_d;
            f3_q       <= f3_d;
            owner_q    <= owner_d;
        end
    end

    // Next state: a granted read latches its request and waits out the latency.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lat_cnt_d  = lat_cnt_q;
        ra_d       = ra_q;
        f3_d       = f3_q;
        owner_d    = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    last_gnt_d = sel_port;
                    if (!sel_we) begin
                        state_d   = ST_READ_WAIT;
                        lat_cnt_d = LAT_INIT;
                        ra_d      = sel_addr;
                        f3_d      = sel_f3;
                        owner_d   = sel_port;
                    end
                end
            end
            ST_READ_WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. Everything is held at zero while reset is asserted.
    always_comb begin
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        mem_wen    = 1'b0;
        mem_funct3 = 3'd0;
        mem_wa     = 32'd0;
        mem_wd     = 32'd0;
        mem_ra     = 32'd0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        m0_gnt     = ~sel_port;
                        m1_gnt     = sel_port;
                        mem_funct3 = sel_f3;
                        if (sel_we) begin
                            mem_wen = 1'b1;
                            mem_wa  = sel_addr;
                            mem_wd  = sel_wdata;
                        end else begin
                            mem_ra = sel_addr;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    mem_ra     = ra_q;
                    mem_funct3 = f3_q;
                    if (lat_cnt_q == 3'd0) begin
                        m0_rvalid = ~owner_q;
                        m1_rvalid = owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data goes straight through to both ports. rvalid selects the owner.
    assign m0_rdata    = mem_rd;
    assign m1_rdata    = mem_rd;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Instance A uses MEM_LAT=1 with round-robin arbitration.
// Instance B uses MEM_LAT=3 with fixed priority. Each instance has its own
// registered memory model.
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a_n, rst_b_n;

    // ---------------- instance A signals ----------------
    logic        a0_req, a0_we, a1_req, a1_we;
    logic [31:0] a0_addr, a0_wdata, a1_addr, a1_wdata;
    logic [2:0]  a0_f3, a1_f3;
    logic        a0_gnt, a1_gnt, a0_rvalid, a1_rvalid;
    logic [31:0] a0_rdata, a1_rdata;
    logic        a_wen;
    logic [2:0]  a_f3;
    logic [31:0] a_wa, a_wd, a_ra, a_rd;
    logic        a_dbg;

    // ---------------- instance B signals ----------------
    logic        b0_req, b0_we, b1_req, b1_we;
    logic [31:0] b0_addr, b0_wdata, b1_addr, b1_wdata;
    logic [2:0]  b0_f3, b1_f3;
    logic        b0_gnt, b1_gnt, b0_rvalid, b1_rvalid;
    logic [31:0] b0_rdata, b1_rdata;
    logic        b_wen;
    logic [2:0]  b_f3;
    logic [31:0] b_wa, b_wd, b_ra, b_rd;
    logic        b_dbg;

    mem_arbiter #(.MEM_LAT(1), .FIXED_PRIO(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .m0_req(a0_req), .m0_we(a0_we), .m0_addr(a0_addr), .m0_wdata(a0_wdata),
        .m0_funct3(a0_f3), .m0_gnt(a0_gnt), .m0_rvalid(a0_rvalid), .m0_rdata(a0_rdata),
        .m1_req(a1_req), .m1_we(a1_we), .m1_addr(a1_addr), .m1_wdata(a1_wdata),
        .m1_funct3(a1_f3), .m1_gnt(a1_gnt), .m1_rvalid(a1_rvalid), .m1_rdata(a1_rdata),
        .mem_wen(a_wen), .mem_funct3(a_f3), .mem_wa(a_wa), .mem_wd(a_wd),
        .mem_ra(a_ra), .mem_rd(a_rd), .dbg_state_o(a_dbg)
    );

    mem_arbiter #(.MEM_LAT(3), .FIXED_PRIO(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .m0_req(b0_req), .m0_we(b0_we), .m0_addr(b0_addr), .m0_wdata(b0_wdata),
        .m0_funct3(b0_f3), .m0_gnt(b0_gnt), .m0_rvalid(b0_rvalid), .m0_rdata(b0_rdata),
        .m1_req(b1_req), .m1_we(b1_we), .m1_addr(b1_addr), .m1_wdata(b1_wdata),
        .m1_funct3(b1_f3), .m1_gnt(b1_gnt), .m1_rvalid(b1_rvalid), .m1_rdata(b1_rdata),
        .mem_wen(b_wen), .mem_funct3(b_f3), .mem_wa(b_wa), .mem_wd(b_wd),
        .mem_ra(b_ra), .mem_rd(b_rd), .dbg_state_o(b_dbg)
    );

    // ---------------- memory models (registered read) ----------------
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    always @(posedge clk) begin
        if (a_wen) mem_a[a_wa[9:2]] <= a_wd;
        a_rd <= mem_a[a_ra[9:2]];
    end

    always @(posedge clk) begin
        if (b_wen) mem_b[b_wa[9:2]] <= b_wd;
        b_rd <= mem_b[b_ra[9:2]];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [0:0]  gnt_exp_a[$];
    logic [0:0]  gnt_exp_b[$];
    logic [32:0] rd_exp_a[$];   // {port, data}
    logic [32:0] rd_exp_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor A: every grant and every read return is matched against the queues.
    always @(negedge clk) begin
        logic [0:0]  eg;
        logic [32:0] er;
        if (a0_gnt || a1_gnt) begin
            chk("gnt_onehot_a", {63'd0, a0_gnt & a1_gnt}, 64'd0);
            if (gnt_exp_a.size() == 0) chk("extra_gnt_a", {62'd0, a1_gnt, a0_gnt}, 64'd0);
            else begin
                eg = gnt_exp_a.pop_front();
                chk("gnt_port_a", {63'd0, a1_gnt}, {63'd0, eg});
            end
        end
        if (a0_rvalid || a1_rvalid) begin
            chk("rvalid_onehot_a", {63'd0, a0_rvalid & a1_rvalid}, 64'd0);
            if (rd_exp_a.size() == 0) chk("extra_rvalid_a", {62'd0, a1_rvalid, a0_rvalid}, 64'd0);
            else begin
                er = rd_exp_a.pop_front();
                chk("rdata_a", {31'd0, a1_rvalid, a1_rvalid ? a1_rdata : a0_rdata}, {31'd0, er});
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        logic [0:0]  eg;
        logic [32:0] er;
        if (b0_gnt || b1_gnt) begin
            chk("gnt_onehot_b", {63'd0, b0_gnt & b1_gnt}, 64'd0);
            if (gnt_exp_b.size() == 0) chk("extra_gnt_b", {62'd0, b1_gnt, b0_gnt}, 64'd0);
            else begin
                eg = gnt_exp_b.pop_front();
                chk("gnt_port_b", {63'd0, b1_gnt}, {63'd0, eg});
            end
        end
        if (b0_rvalid || b1_rvalid) begin
            chk("rvalid_onehot_b", {63'd0, b0_rvalid & b1_rvalid}, 64'd0);
            if (rd_exp_b.size() == 0) chk("extra_rvalid_b", {62'd0, b1_rvalid, b0_rvalid}, 64'd0);
            else begin
                er = rd_exp_b.pop_front();
                chk("rdata_b", {31'd0, b1_rvalid, b1_rvalid ? b1_rdata : b0_rdata}, {31'd0, er});
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a0_req = 0; a0_we = 0; a0_addr = 0; a0_wdata = 0; a0_f3 = 0;
        a1_req = 0; a1_we = 0; a1_addr = 0; a1_wdata = 0; a1_f3 = 0;
        b0_req = 0; b0_we = 0; b0_addr = 0; b0_wdata = 0; b0_f3 = 0;
        b1_req = 0; b1_we = 0; b1_addr = 0; b1_wdata = 0; b1_f3 = 0;

        // Reset with both ports requesting: nothing may be granted.
        a0_we = 1; a0_addr = 32'h200; a0_wdata = 32'h1111_0000; a0_f3 = 3'b010;
        a1_we = 1; a1_addr = 32'h204; a1_wdata = 32'h2222_0000; a1_f3 = 3'b010;
        b0_we = 1; b0_addr = 32'h200; b0_wdata = 32'h3333_0000; b0_f3 = 3'b010;
        b1_we = 1; b1_addr = 32'h204; b1_wdata = 32'h4444_0000; b1_f3 = 3'b010;
        a0_req = 1; a1_req = 1; b0_req = 1; b1_req = 1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_gnt_a", {62'd0, a1_gnt, a0_gnt}, 64'd0);
        chk("rst_wen_a", {63'd0, a_wen}, 64'd0);
        chk("rst_ra_a", {32'd0, a_ra}, 64'd0);
        chk("rst_gnt_b", {62'd0, b1_gnt, b0_gnt}, 64'd0);
        chk("rst_state_a", {63'd0, a_dbg}, 64'd0);

        // Release into six cycles of write contention:
        // round-robin alternates starting at port 0, fixed priority always picks 0.
        for (int i = 0; i < 6; i++) begin
            gnt_exp_a.push_back(1'(i % 2));
            gnt_exp_b.push_back(1'b0);
        end
        tick();
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (6) tick();
        a0_req = 0; a1_req = 0; b0_req = 0; b1_req = 0;
        chk("rr_all_granted_a", 64'(gnt_exp_a.size()), 64'd0);
        chk("prio_all_granted_b", 64'(gnt_exp_b.size()), 64'd0);

        // Single write on A, port 0.
        a0_we = 1; a0_addr = 32'h100; a0_wdata = 32'hDEAD_BEEF; a0_f3 = 3'b010;
        gnt_exp_a.push_back(1'b0);
        a0_req = 1;
        @(negedge clk);
        chk("wr_gnt_a", {63'd0, a0_gnt}, 64'd1);
        chk("wr_wen_a", {63'd0, a_wen}, 64'd1);
        chk("wr_wa_a", {32'd0, a_wa}, 64'h100);
        chk("wr_wd_a", {32'd0, a_wd}, 64'hDEAD_BEEF);
        chk("wr_f3_a", {61'd0, a_f3}, 64'd2);
        tick();
        a0_req = 0;
        @(negedge clk);
        chk("wr_wen_off_a", {63'd0, a_wen}, 64'd0);
        tick();

        // Port 1 read of 0x100 on A (latency 1).
        a1_we = 0; a1_addr = 32'h100; a1_f3 = 3'b010;
        gnt_exp_a.push_back(1'b1);
        rd_exp_a.push_back({1'b1, 32'hDEAD_BEEF});
        a1_req = 1;
        @(negedge clk);
        chk("rd_gnt_a", {63'd0, a1_gnt}, 64'd1);
        chk("rd_ra_a", {32'd0, a_ra}, 64'h100);
        tick();
        // The arbiter must ignore any field changes after the grant.
        a1_req = 0; a1_addr = 32'hFFC;
        @(negedge clk);
        chk("rd_ra_hold_a", {32'd0, a_ra}, 64'h100);
        chk("rd_rvalid1_a", {63'd0, a1_rvalid}, 64'd1);
        chk("rd_rvalid0_a", {63'd0, a0_rvalid}, 64'd0);
        tick();
        @(negedge clk);
        chk("rd_done_state_a", {63'd0, a_dbg}, 64'd0);
        chk("rd_rvalid_off_a", {63'd0, a1_rvalid}, 64'd0);
        tick();

        // Preload B memory: port 1 writes 0x12345678 to address 0x40.
        b1_we = 1; b1_addr = 32'h40; b1_wdata = 32'h1234_5678; b1_f3 = 3'b010;
        gnt_exp_b.push_back(1'b1);
        b1_req = 1;
        @(negedge clk);
        chk("pre_gnt_b", {63'd0, b1_gnt}, 64'd1);
        tick();
        b1_req = 0;
        tick();

        // B, latency 3: port 0 reads at T while port 1 also requests a write from T.
        b0_we = 0; b0_addr = 32'h40; b0_f3 = 3'b010;
        b1_we = 1; b1_addr = 32'h44; b1_wdata = 32'hA5A5_5A5A; b1_f3 = 3'b010;
        gnt_exp_b.push_back(1'b0);
        gnt_exp_b.push_back(1'b1);
        rd_exp_b.push_back({1'b0, 32'h1234_5678});
        b0_req = 1; b1_req = 1;
        @(negedge clk);
        chk("blk_gnt0_b", {63'd0, b0_gnt}, 64'd1);
        chk("blk_ra_b", {32'd0, b_ra}, 64'h40);
        tick();
        b0_req = 0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("blk_nognt_b", {62'd0, b1_gnt, b0_gnt}, 64'd0);
            chk("blk_norv_b", {63'd0, b0_rvalid}, 64'd0);
            chk("blk_ra_hold_b", {32'd0, b_ra}, 64'h40);
            tick();
        end
        @(negedge clk);
        chk("blk_rvalid_b", {63'd0, b0_rvalid}, 64'd1);
        chk("blk_nognt_t3_b", {62'd0, b1_gnt, b0_gnt}, 64'd0);
        tick();
        @(negedge clk);
        chk("blk_gnt1_b", {63'd0, b1_gnt}, 64'd1);
        chk("blk_wen_b", {63'd0, b_wen}, 64'd1);
        chk("blk_wa_b", {32'd0, b_wa}, 64'h44);
        tick();
        b1_req = 0;
        tick();

        // B: reset asserted one cycle into a read; the read must never return.
        b0_we = 0; b0_addr = 32'h40; b0_f3 = 3'b010;
        gnt_exp_b.push_back(1'b0);
        b0_req = 1;
        @(negedge clk);
        chk("rstrd_gnt_b", {63'd0, b0_gnt}, 64'd1);
        tick();
        b0_req = 0;
        rst_b_n = 1'b0;
        @(negedge clk);
        chk("rstrd_norv_b", {63'd0, b0_rvalid}, 64'd0);
        tick();
        rst_b_n = 1'b1;
        @(negedge clk);
        chk("rstrd_idle_b", {63'd0, b_dbg}, 64'd0);
        repeat (5) tick();

        chk("gnt_q_empty_a", 64'(gnt_exp_a.size()), 64'd0);
        chk("gnt_q_empty_b", 64'(gnt_exp_b.size()), 64'd0);
        chk("rd_q_empty_a", 64'(rd_exp_a.size()), 64'd0);
        chk("rd_q_empty_b", 64'(rd_exp_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
